// File: rtl/jam_cost_server.sv
// Cost-table server for the job-assignment engine: loads a 64-entry 8x8 cost table,
// serves registered costs by (W,J), counts address changes, and captures the engine result.
module jam_cost_server #(
    parameter int QCNT_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  logic [6:0]        load_data,
    output logic              load_ready,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [6:0]        Cost,
    input  logic [3:0]        MatchCount,
    input  logic [9:0]        MinCost,
    input  logic              Valid,
    output logic              res_done,
    output logic [3:0]        res_match,
    output logic [9:0]        res_min,
    output logic [QCNT_W-1:0] query_cnt
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [5:0]        addr_reg;
    logic [6:0]        cost_mem [0:63];
    logic [6:0]        cost_reg;
    logic [5:0]        prev_reg;
    logic              prev_valid_reg;
    logic [QCNT_W-1:0] qcnt_reg;
    logic              done_reg;
    logic [3:0]        match_reg;
    logic [9:0]        min_reg;

    logic [5:0]        rd_addr;
    logic              load_accept;
    logic              addr_change;
    logic              qcnt_sat;

    assign rd_addr     = {W, J};
    assign load_accept = (state_reg == LOAD) && load_valid;
    // The first serving cycle always counts as a change.
    assign addr_change = !prev_valid_reg || (rd_addr != prev_reg);
    assign qcnt_sat    = &qcnt_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            LOAD:    if (load_accept && (addr_reg == 6'd63)) state_next = SERVE;
            SERVE:   if (Valid) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= LOAD;
            addr_reg       <= 6'd0;
            cost_reg       <= 7'd0;
            prev_reg       <= 6'd0;
            prev_valid_reg <= 1'b0;
            qcnt_reg       <= '0;
            done_reg       <= 1'b0;
            match_reg      <= 4'd0;
            min_reg        <= 10'd0;
        end else begin
            state_reg <= state_next;
            if (load_accept) addr_reg <= addr_reg + 6'd1;

            if (state_reg == LOAD) cost_reg <= 7'd0;
            else                   cost_reg <= cost_mem[rd_addr];

            if (state_reg == SERVE) begin
                prev_reg       <= rd_addr;
                prev_valid_reg <= 1'b1;
                if (addr_change && !qcnt_sat)
                    qcnt_reg <= qcnt_reg + {{(QCNT_W-1){1'b0}}, 1'b1};
                if (Valid) begin
                    done_reg  <= 1'b1;
                    match_reg <= MatchCount;
                    min_reg   <= MinCost;
                end
            end else if (state_reg == LOAD) begin
                prev_valid_reg <= 1'b0;
            end
        end
    end

    // Table storage is deliberately outside the reset domain so it maps to block RAM.
    always_ff @(posedge CLK) begin
        if (load_accept && RST) cost_mem[addr_reg] <= load_data;
    end

    assign load_ready = (state_reg == LOAD);
    assign Cost       = cost_reg;
    assign res_done   = done_reg;
    assign res_match  = match_reg;
    assign res_min    = min_reg;
    assign query_cnt  = qcnt_reg;

endmodule

// File: doc/jam_cost_server.md
JAM_COST_SERVER -- requirements
Module: jam_cost_server

Interface
REQ-001 SHALL have parameter: QCNT_W, default 7, width of saturating query counter.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: load_valid  input  1  table-load data strobe.
REQ-005 SHALL have port: load_data  input  7  cost entry, row-major order, worker 0 job 0 first.
REQ-006 SHALL have port: load_ready  output  1  table accepts a load entry this cycle.
REQ-007 SHALL have port: W  input  3  worker index requested by the job-assignment engine.
REQ-008 SHALL have port: J  input  3  job index requested by the job-assignment engine.
REQ-009 SHALL have port: Cost  output  7  registered cost of entry (W,J).
REQ-010 SHALL have port: MatchCount  input  4  engine result, count of minimum-cost assignments.
REQ-011 SHALL have port: MinCost  input  10  engine result, minimum total cost.
REQ-012 SHALL have port: Valid  input  1  engine result strobe.
REQ-013 SHALL have port: res_done  output  1  result captured.
REQ-014 SHALL have port: res_match  output  4  captured MatchCount.
REQ-015 SHALL have port: res_min  output  10  captured MinCost.
REQ-016 SHALL have port: query_cnt  output  QCNT_W  number of address changes served, saturating.

Function
REQ-017 SHALL implement three states: LOAD, SERVE, DONE.
REQ-018 In LOAD, load_ready SHALL be 1; each cycle with load_valid=1 SHALL write load_data to table[addr] and increment the 6-bit addr.
REQ-019 When the 64th entry (addr=63) is accepted, the FSM SHALL go to SERVE next cycle, with load_ready=0 from that cycle onward.
REQ-020 load_valid outside LOAD SHALL be ignored; the table SHALL NOT change.
REQ-021 In LOAD, Cost SHALL be 0 and Valid SHALL be ignored.
REQ-022 In SERVE and DONE, Cost SHALL update every rising edge to table[W*8+J], giving one-cycle latency from a (W,J) change to Cost.
REQ-023 Cost SHALL be stable between rising edges so the engine can sample it on the falling edge.
REQ-024 In SERVE, query_cnt SHALL increment when {W,J} differs from the previous cycle's {W,J}; the first SERVE cycle SHALL count as a change.
REQ-025 query_cnt SHALL saturate at 2^QCNT_W-1 and SHALL freeze in DONE.
REQ-026 In SERVE, Valid=1 sampled on a rising edge SHALL capture MatchCount into res_match and MinCost into res_min, set res_done=1, and go to DONE.
REQ-027 In DONE, res_* SHALL hold; further Valid pulses SHALL be ignored; the state SHALL be left only by reset.
REQ-028 A Valid arriving in the same cycle as the last load entry SHALL be ignored.
REQ-029 The table SHALL be 64 x 7-bit storage and SHALL NOT be cleared by reset.

Reset
REQ-030 When RST=0, the block SHALL enter LOAD immediately regardless of the clock.
REQ-031 Reset SHALL set addr=0, Cost=0, res_done=0, res_match=0, res_min=0, query_cnt=0, load_ready=1 (after release).
REQ-032 Reset during LOAD or SERVE SHALL abandon progress; the next load SHALL restart at entry 0 and overwrite the table.

Verification
REQ-033 Load table[i]=i (i=0..63) with back-to-back load_valid -> load_ready drops after the 64th accept; with W=3,J=5, Cost=29 one cycle later.
REQ-034 Load with load_valid gaps (every other cycle) -> exactly 64 accepts; table contents match; a load_valid pulse after SERVE is entered leaves table unchanged.
REQ-035 In SERVE, sweep (W,J) over all 64 pairs, one per cycle -> Cost matches each entry with 1-cycle latency; query_cnt=64; hold (W,J) 10 cycles -> query_cnt unchanged.
REQ-036 Pulse Valid with MatchCount=2, MinCost=10'd300 -> res_done=1, res_match=2, res_min=300; a second Valid with other values -> outputs unchanged.
REQ-037 Assert RST=0 mid-SERVE between clock edges -> Cost=0, res_done=0, query_cnt=0, load_ready=1 without a clock edge; reload a new table -> new costs served.
REQ-038 Use QCNT_W=3 with 10 distinct address changes -> query_cnt saturates at 7.
